// File: rtl/mem_responder.sv
// mem_responder: multi-channel fixed-latency memory responder with a preload port.
module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16,
  parameter int NUM_CHANNELS = 1,
  parameter int WRITE_ENABLE = 1,
  parameter int LATENCY      = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready,
  input  logic                              init_valid,
  input  logic [ADDR_BITS-1:0]              init_address,
  input  logic [DATA_BITS-1:0]              init_data
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [2:0] {IDLE, BUSY_RD, BUSY_WR, RESPOND, RELEASE} state_t;
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  logic [NUM_CHANNELS-1:0] commit;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] commit_addr;
  logic [NUM_CHANNELS*DATA_BITS-1:0] commit_data;
  // Later assignments win: init first, then channels in ascending index order.
  always_ff @(posedge clk) begin
    if (init_valid) mem[init_address] <= init_data;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (commit[i]) mem[commit_addr[i*ADDR_BITS +: ADDR_BITS]] <= commit_data[i*DATA_BITS +: DATA_BITS];
  end
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : ch
    state_t state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata, rdata;
    logic is_wr, rv, wv, done;
    assign rv = mem_read_valid[c];
    assign wv = mem_write_valid[c] && (WRITE_ENABLE != 0);
    assign done = cnt == '0;
    always_comb begin
      nxt = state;
      cnt_nxt = cnt;
      case (state)
        IDLE: begin
          nxt = rv ? BUSY_RD : wv ? BUSY_WR : IDLE;
          cnt_nxt = (rv || wv) ? CW'(LATENCY - 1) : cnt;
        end
        BUSY_RD: begin
          nxt = !rv ? IDLE : done ? RESPOND : BUSY_RD;
          cnt_nxt = done ? cnt : cnt - 1'b1;
        end
        BUSY_WR: begin
          nxt = !wv ? IDLE : done ? RESPOND : BUSY_WR;
          cnt_nxt = done ? cnt : cnt - 1'b1;
        end
        RESPOND: nxt = RELEASE;
        RELEASE: nxt = (rv || wv) ? RELEASE : IDLE;
        default: nxt = IDLE;
      endcase
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        cnt <= '0;
        rdata <= '0;
        is_wr <= 1'b0;
      end else begin
        state <= nxt;
        cnt <= cnt_nxt;
        if (state == BUSY_RD && rv && done) rdata <= mem[addr];
        if (state == IDLE && (rv || wv)) is_wr <= !rv;
      end
      if (state == IDLE && (rv || wv)) begin
        addr <= rv ? mem_read_address[c*ADDR_BITS +: ADDR_BITS] : mem_write_address[c*ADDR_BITS +: ADDR_BITS];
        wdata <= mem_write_data[c*DATA_BITS +: DATA_BITS];
      end
    end
    assign commit[c] = !reset && state == BUSY_WR && wv && done;
    assign commit_addr[c*ADDR_BITS +: ADDR_BITS] = addr;
    assign commit_data[c*DATA_BITS +: DATA_BITS] = wdata;
    assign mem_read_ready[c] = state == RESPOND && !is_wr;
    assign mem_write_ready[c] = state == RESPOND && is_wr;
    assign mem_read_data[c*DATA_BITS +: DATA_BITS] = rdata;
  end
endmodule
